dec_lane_gearbox: RTL and testbench

- Parametrised fp32 lane-width converter between decomposition levels.
- Accepts IN_LANES samples per input beat and emits OUT_LANES samples per output beat, buffering in a sample-granular circular store.
- Feeds deeper decomposition stages (L5 and beyond), where one L4 output beat per clk_78_125 cycle holds fewer samples than a stage consumes.
- Adds output backpressure, end-of-record flush with padding, and overflow detection. Upstream decompose stages are valid-only.

---
 rtl/dec_lane_gearbox.sv | 170 +++++++++++++++++
 tb/tb_dec_lane_gearbox.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_lane_gearbox.sv
// fp32 lane-width gearbox: IN_LANES samples in, OUT_LANES samples out, sample-granular ring buffer,
// flush with tail padding and sticky overflow. Define PAD_REPEAT_EN to pad with the last valid sample.

module dec_lane_gearbox_rd_lane #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int LANE  = 0,
    parameter int PW    = 4,
    parameter int CW    = 5
) (
    input  logic                      vld,
    input  logic [CW-1:0]             cnt,
    input  logic [PW-1:0]             rd_ptr,
    input  logic [DEPTH-1:0][DW-1:0]  mem,
    output logic [DW-1:0]             sample
);
    logic [PW-1:0] idx;
`ifdef PAD_REPEAT_EN
    logic [PW-1:0] last_idx;
`endif

    always_comb begin
        idx    = rd_ptr + PW'(LANE);
`ifdef PAD_REPEAT_EN
        // cnt == DEPTH truncates to 0, so rd_ptr-1 is still the newest sample
        last_idx = rd_ptr + cnt[PW-1:0] - PW'(1);
`endif
        sample = '0;
        if (vld) begin
            if (CW'(LANE) < cnt) begin
                sample = mem[idx];
            end else begin
`ifdef PAD_REPEAT_EN
                sample = mem[last_idx];
`else
                sample = '0;
`endif
            end
        end
    end
endmodule

module dec_lane_gearbox #(
    parameter int DW        = 32,
    parameter int IN_LANES  = 1,
    parameter int OUT_LANES = 2,
    parameter int DEPTH     = 16
) (
    input  logic                       clk_78_125,
    input  logic                       rst,
    input  logic                       din_valid,
    input  logic [IN_LANES*DW-1:0]     din,
    output logic                       din_ready,
    output logic                       dout_valid,
    output logic [OUT_LANES*DW-1:0]    dout,
    input  logic                       dout_ready,
    output logic                       dout_last,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] IN_C    = CW'(IN_LANES);
    localparam logic [CW-1:0] OUT_C   = CW'(OUT_LANES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic                     ovf_q, ovf_d;
    logic                     fdone_q, fdone_d;

    logic                     push, pop, drop;
    logic [CW-1:0]            pop_n;
    logic [OUT_LANES-1:0][DW-1:0] lane_dat;

    always_comb begin
        din_ready  = (state_q == RUN) && ((DEPTH_C - count_q) >= IN_C);
        dout_valid = (state_q == RUN) ? (count_q >= OUT_C) : (count_q != '0);
        dout_last  = (state_q == FLUSH) && (count_q != '0) && (count_q <= OUT_C);
        push       = din_valid && din_ready;
        drop       = din_valid && !din_ready;
        pop        = dout_valid && dout_ready;
        // a partial flush beat consumes everything that is left
        pop_n      = (count_q < OUT_C) ? count_q : OUT_C;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            for (int i = 0; i < IN_LANES; i++) begin
                mem_d[wr_ptr_q + PW'(i)] = din[i*DW +: DW];
            end
            wr_ptr_d = wr_ptr_q + PW'(IN_LANES);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + pop_n[PW-1:0];
        end
        count_d = count_q + (push ? IN_C : '0) - (pop ? pop_n : '0);
        ovf_d   = ovf_q | drop;
    end

    always_comb begin
        state_d = state_q;
        fdone_d = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) begin
                    if (count_d == '0) fdone_d = 1'b1;
                    else               state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && (count_d == '0)) begin
                    state_d = RUN;
                    fdone_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_78_125 or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            fdone_q  <= fdone_d;
        end
    end

    // storage carries no reset: contents are only visible through count_q
    always_ff @(posedge clk_78_125) begin
        mem_q <= mem_d;
    end

    for (genvar g = 0; g < OUT_LANES; g++) begin : g_lane
        dec_lane_gearbox_rd_lane #(
            .DW(DW), .DEPTH(DEPTH), .LANE(g), .PW(PW), .CW(CW)
        ) u_lane (
            .vld    (dout_valid),
            .cnt    (count_q),
            .rd_ptr (rd_ptr_q),
            .mem    (mem_q),
            .sample (lane_dat[g])
        );
    end

    assign dout       = lane_dat;
    assign fill_level = count_q;
    assign overflow   = ovf_q;
    assign flush_done = fdone_q;
endmodule

// File: tb/tb_dec_lane_gearbox.sv
// Bench for dec_lane_gearbox: two configurations (1->2 lanes depth 8, 4->2 lanes depth 16) checked
// every cycle against a queue-based model, plus directed checks of the flush/overflow/reset cases.

module tb_dec_lane_gearbox;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         dv_a, dr_a, fl_a, rdy_a, vld_a, last_a, fd_a, ovf_a;
    logic [31:0]  din_a;
    logic [63:0]  dout_a;
    logic [3:0]   fill_a;
    logic         dv_b, dr_b, fl_b, rdy_b, vld_b, last_b, fd_b, ovf_b;
    logic [127:0] din_b;
    logic [63:0]  dout_b;
    logic [4:0]   fill_b;

    dec_lane_gearbox #(.DW(32), .IN_LANES(1), .OUT_LANES(2), .DEPTH(8)) u_a (
        .clk_78_125(clk), .rst(rst), .din_valid(dv_a), .din(din_a), .din_ready(rdy_a),
        .dout_valid(vld_a), .dout(dout_a), .dout_ready(dr_a), .dout_last(last_a),
        .flush(fl_a), .flush_done(fd_a), .fill_level(fill_a), .overflow(ovf_a));

    dec_lane_gearbox #(.DW(32), .IN_LANES(4), .OUT_LANES(2), .DEPTH(16)) u_b (
        .clk_78_125(clk), .rst(rst), .din_valid(dv_b), .din(din_b), .din_ready(rdy_b),
        .dout_valid(vld_b), .dout(dout_b), .dout_ready(dr_b), .dout_last(last_b),
        .flush(fl_b), .flush_done(fd_b), .fill_level(fill_b), .overflow(ovf_b));

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    // reference model: plain sample queue plus flush/overflow/done flags
    int          m_in, m_out, m_depth;
    logic [31:0] mq[$];
    bit          m_fl, m_ovf, m_fd;

`ifdef PAD_REPEAT_EN
    localparam bit PAD_REP = 1'b1;
`else
    localparam bit PAD_REP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    function automatic bit m_rdy();
        return !m_fl && ((m_depth - mq.size()) >= m_in);
    endfunction

    function automatic bit m_vld();
        return m_fl ? (mq.size() > 0) : (mq.size() >= m_out);
    endfunction

    function automatic bit m_last();
        return m_fl && (mq.size() > 0) && (mq.size() <= m_out);
    endfunction

    function automatic logic [63:0] m_dout();
        logic [63:0] r;
        logic [31:0] pad;
        r = '0;
        pad = '0;
        if (m_vld()) begin
            if (PAD_REP) pad = mq[mq.size()-1];
            for (int i = 0; i < 2; i++) r[i*32 +: 32] = (i < mq.size()) ? mq[i] : pad;
        end
        return r;
    endfunction

    task automatic m_clear(input int s);
        mq.delete();
        m_fl = 0; m_ovf = 0; m_fd = 0;
        m_in = (s != 0) ? 4 : 1;
        m_out = 2;
        m_depth = (s != 0) ? 16 : 8;
    endtask

    task automatic m_edge(input bit dv, input logic [127:0] d, input bit dr, input bit fl);
        bit rdy, pop;
        int n;
        rdy = m_rdy();
        pop = m_vld() && dr;
        m_fd = 0;
        if (pop) begin
            n = (mq.size() < m_out) ? mq.size() : m_out;
            repeat (n) void'(mq.pop_front());
        end
        if (dv && rdy) begin
            for (int i = 0; i < m_in; i++) mq.push_back(d[i*32 +: 32]);
        end else if (dv) begin
            m_ovf = 1;
        end
        if (!m_fl && fl) begin
            if (mq.size() == 0) m_fd = 1;
            else                m_fl = 1;
        end else if (m_fl && pop && mq.size() == 0) begin
            m_fl = 0;
            m_fd = 1;
        end
    endtask

    task automatic cmp_all();
        if (sel == 0) begin
            chk("rdy", 128'(rdy_a), 128'(m_rdy()));
            chk("vld", 128'(vld_a), 128'(m_vld()));
            chk("dout", 128'(dout_a), 128'(m_dout()));
            chk("last", 128'(last_a), 128'(m_last()));
            chk("fill", 128'(fill_a), 128'(mq.size()));
            chk("ovf", 128'(ovf_a), 128'(m_ovf));
            chk("fdone", 128'(fd_a), 128'(m_fd));
        end else begin
            chk("rdy_b", 128'(rdy_b), 128'(m_rdy()));
            chk("vld_b", 128'(vld_b), 128'(m_vld()));
            chk("dout_b", 128'(dout_b), 128'(m_dout()));
            chk("last_b", 128'(last_b), 128'(m_last()));
            chk("fill_b", 128'(fill_b), 128'(mq.size()));
            chk("ovf_b", 128'(ovf_b), 128'(m_ovf));
            chk("fdone_b", 128'(fd_b), 128'(m_fd));
        end
    endtask

    task automatic drive(input bit dv, input logic [127:0] d, input bit dr, input bit fl);
        dv_a = 0; din_a = '0; dr_a = 0; fl_a = 0;
        dv_b = 0; din_b = '0; dr_b = 0; fl_b = 0;
        if (sel == 0) begin
            dv_a = dv; din_a = d[31:0]; dr_a = dr; fl_a = fl;
        end else begin
            dv_b = dv; din_b = d; dr_b = dr; fl_b = fl;
        end
    endtask

    // one modelled clock: check state at negedge, drive, then advance model at posedge
    task automatic step(input bit dv, input logic [127:0] d, input bit dr, input bit fl);
        @(negedge clk);
        cmp_all();
        drive(dv, d, dr, fl);
        @(posedge clk);
        m_edge(dv, d, dr, fl);
    endtask

    task automatic do_reset(input int s);
        sel = s;
        drive(0, '0, 0, 0);
        rst = 1'b1;
        m_clear(s);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [31:0] pad3;
        pad3 = PAD_REP ? 32'h40400000 : 32'h0;
        rst = 1'b1;
        drive(0, '0, 0, 0);
        do_reset(0);
        #1;
        chk("rst_vld", 128'(vld_a), 128'(0));
        chk("rst_fill", 128'(fill_a), 128'(0));
        chk("rst_ovf", 128'(ovf_a), 128'(0));
        chk("rst_dout", 128'(dout_a), 128'(0));
        chk("rst_rdy", 128'(rdy_a), 128'(1));

        // two single-sample pushes form one beat
        step(1, 128'h3f800000, 1, 0);
        step(1, 128'h40000000, 1, 0);
        #1;
        chk("t1_vld", 128'(vld_a), 128'(1));
        chk("t1_dout", 128'(dout_a), 128'h40000000_3f800000);
        step(0, '0, 1, 0);
        #1 chk("t1_fill", 128'(fill_a), 128'(0));

        // flush of three samples: full beat then padded tail
        step(1, 128'h3f800000, 0, 0);
        step(1, 128'h40000000, 0, 0);
        step(1, 128'h40400000, 0, 0);
        step(0, '0, 0, 1);
        #1;
        chk("t3_dout0", 128'(dout_a), 128'h40000000_3f800000);
        chk("t3_last0", 128'(last_a), 128'(0));
        step(0, '0, 1, 0);
        #1;
        chk("t3_dout1", 128'(dout_a), {64'h0, pad3, 32'h40400000});
        chk("t3_last1", 128'(last_a), 128'(1));
        step(0, '0, 1, 0);
        #1;
        chk("t3_fdone", 128'(fd_a), 128'(1));
        chk("t3_vld", 128'(vld_a), 128'(0));
        step(0, '0, 1, 0);
        #1 chk("t3_fdone_pulse", 128'(fd_a), 128'(0));

        // flush of an empty buffer
        step(0, '0, 1, 1);
        #1;
        chk("t4_fdone", 128'(fd_a), 128'(1));
        chk("t4_vld", 128'(vld_a), 128'(0));
        chk("t4_rdy", 128'(rdy_a), 128'(1));
        step(0, '0, 1, 0);
        #1 chk("t4_fdone_pulse", 128'(fd_a), 128'(0));

        // fill to capacity across the wrap, overflow, then drain
        for (int i = 0; i < 8; i++) step(1, 128'(32'h41000000 + i), 0, 0);
        #1;
        chk("t2_fill", 128'(fill_a), 128'(8));
        chk("t2_rdy", 128'(rdy_a), 128'(0));
        step(1, 128'hdeadbeef, 0, 0);
        #1 chk("t2_ovf", 128'(ovf_a), 128'(1));
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        #1 chk("t2_ovf_sticky", 128'(ovf_a), 128'(1));

        // asynchronous reset in the middle of a flush
        for (int i = 0; i < 5; i++) step(1, 128'(32'h42000000 + i), 0, 0);
        step(0, '0, 0, 1);
        step(1, 128'h12345678, 0, 0);
        #1 drive(0, '0, 0, 0);
        #1 rst = 1'b1;
        m_clear(0);
        #1;
        chk("t5_vld", 128'(vld_a), 128'(0));
        chk("t5_fill", 128'(fill_a), 128'(0));
        chk("t5_ovf", 128'(ovf_a), 128'(0));
        chk("t5_dout", 128'(dout_a), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        step(1, 128'h3f000000, 1, 0);
        step(1, 128'h3e800000, 1, 0);
        #1 chk("t5_dout_after", 128'(dout_a), 128'h3e800000_3f000000);

        // random traffic, narrow config, drops allowed
        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 9) < 6, 128'($urandom), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0);

        // wide config: stream with din_valid honouring ready
        do_reset(1);
        for (int c = 0; c < 40; c++) step(m_rdy(), rnd128(), 1, 0);
        for (int c = 0; c < 300; c++)
            step(m_rdy() && ($urandom_range(0, 9) < 8), rnd128(), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0);
        #1 chk("t6_no_ovf", 128'(ovf_b), 128'(0));
        for (int c = 0; c < 200; c++)
            step($urandom_range(0, 9) < 7, rnd128(), $urandom_range(0, 9) < 5,
                 $urandom_range(0, 29) == 0);
        @(negedge clk);
        cmp_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
